generador_velocidad: RTL and testbench
======================================

Name: generador_velocidad

Overview:
Upstream speed stage for the variable-speed light game (juego_luces_vel_var).
- Conditions the two raw speed push-buttons: synchronises, debounces and edge-detects them.
- Keeps a saturating speed level.
- Emits a single-cycle TICK strobe whose period depends on the level. The light-sequence FSM advances one step per TICK.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles a synchronised key must stay unchanged before its debounced state updates (20 ms at 50 MHz)
NUM_LEVELS, 8, number of speed levels, 0 = slowest, NUM_LEVELS-1 = fastest; minimum 2
RESET_LEVEL, 3, level loaded on reset; must be < NUM_LEVELS
BASE_PERIOD, 6_250_000, TICK period in cycles at the fastest level
LEVEL_W, 3, width of NIVEL; must satisfy 2^LEVEL_W >= NUM_LEVELS
CNT_W, 27, width of the period and debounce counters; must hold BASE_PERIOD*NUM_LEVELS and DEBOUNCE_CYCLES

Ports:
CLK_50  input  1  system clock, 50 MHz
RST  input  1  asynchronous, active-high reset
ENABLE  input  1  1 = tick generation runs; 0 = period counter frozen
KEY_UP_N  input  1  raw button, active-low, asynchronous to CLK_50; press = faster
KEY_DOWN_N  input  1  raw button, active-low, asynchronous to CLK_50; press = slower
TICK  output  1  registered one-cycle strobe, one per period
NIVEL  output  LEVEL_W  current speed level
LIMITE  output  1  1 when NIVEL is 0 or NUM_LEVELS-1

Behaviour:
Reset, asynchronous, takes effect without a clock edge:
- sync flops = 1; debounced states = 1 (released); debounce and period counters = 0
- NIVEL = RESET_LEVEL; TICK = 0
- LIMITE is combinational from NIVEL

Input path, per key, identical and independent:
- Two-flop synchroniser.
- Debounce counter: cleared on any cycle where the synced value equals the debounced state.
- Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced state takes the synced value and the counter clears.
- Press event: one-cycle pulse on a debounced 1->0 transition. Release generates no event.
- Latency: KEY_x_N held low from before edge k changes NIVEL at edge k+DEBOUNCE_CYCLES+2. Exactly one event per press regardless of hold time.
- Glitches shorter than DEBOUNCE_CYCLES synced cycles are filtered completely.

Level register:
- up event only: NIVEL+1 unless NIVEL = NUM_LEVELS-1, which is ignored (saturate, no wrap)
- down event only: NIVEL-1 unless NIVEL = 0, which is ignored
- up and down events in the same cycle: NIVEL unchanged
- level changes are accepted regardless of ENABLE

Period generator:
- PERIOD = BASE_PERIOD * (NUM_LEVELS - NIVEL), computed combinationally in CNT_W bits.
- With ENABLE=1: counter increments each cycle. When counter = PERIOD-1, counter -> 0 and TICK = 1 for the next cycle only.
- With ENABLE=0: counter holds and TICK = 0. On re-enable, counting resumes from the held value.
- On any cycle where NIVEL actually changes: counter -> 0 and no TICK that cycle. The next TICK comes a full new PERIOD later.
- A saturated, ignored press does not clear the counter.
- A TICK due in the same cycle as a level change is suppressed.
- TICK is never asserted for two consecutive cycles unless PERIOD = 1, which is legal only if BASE_PERIOD = 1 at the top level.

Reset mid-operation:
- all state returns to reset values immediately
- a key held low through RST release is treated as a new press once debounced

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, NUM_LEVELS=4, RESET_LEVEL=1, BASE_PERIOD=5, T=20 ns.
1. Release RST with ENABLE=1 and keys high -> NIVEL=1, LIMITE=0, TICK pulses one cycle every 15 cycles. The first pulse is 15 cycles after RST release.
2. KEY_UP_N low 3 cycles then high -> NIVEL stays 1. KEY_UP_N low 12 cycles -> NIVEL=2 exactly 6 edges after the low is sampled, a single increment. The following TICK comes 10 cycles after the change. Release -> no change.
3. Four debounced up presses from 1 -> NIVEL 2, 3, 3, 3; LIMITE=1 from the first 3. The ignored presses do not disturb TICK spacing (5 cycles). Then four down presses -> 2, 1, 0, 0; LIMITE=1 at 0 with period 20.
4. KEY_UP_N and KEY_DOWN_N fall on the same edge and are held -> events coincide, NIVEL unchanged, period counter not cleared.
5. ENABLE=0 for 30 cycles after 7 cycles into a 15-cycle period -> no TICK while disabled. After ENABLE=1, the first TICK comes 8 cycles later.
6. Assert RST for 3 ns mid-period with NIVEL=3 -> NIVEL=1 and TICK=0 immediately, before the next CLK_50 edge. Normal 15-cycle ticking follows.

Source files
------------

// File: rtl/generador_velocidad.sv
// Speed stage for the variable-speed light game: conditions the two speed keys,
// keeps a saturating speed level and emits a level-dependent one-cycle TICK.
module generador_velocidad #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int NUM_LEVELS      = 8,
    parameter int RESET_LEVEL     = 3,
    parameter int BASE_PERIOD     = 6_250_000,
    parameter int LEVEL_W         = 3,
    parameter int CNT_W           = 27
) (
    input  logic               CLK_50,
    input  logic               RST,
    input  logic               ENABLE,
    input  logic               KEY_UP_N,
    input  logic               KEY_DOWN_N,
    output logic               TICK,
    output logic [LEVEL_W-1:0] NIVEL,
    output logic               LIMITE
);

    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   BASE_CNT    = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0]   LEVELS_CNT  = CNT_W'(NUM_LEVELS);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX   = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE   = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_RESET = LEVEL_W'(RESET_LEVEL);
    localparam int                 KEY_UP      = 0;
    localparam int                 KEY_DN      = 1;

    logic [1:0]         key_raw;
    logic [1:0]         key_meta;
    logic [1:0]         key_sync;
    logic [1:0]         key_deb;
    logic [1:0]         key_deb_q;
    logic [1:0]         press;
    logic [CNT_W-1:0]   deb_cnt [2];
    logic [LEVEL_W-1:0] nivel_next;
    logic               level_change;
    logic [CNT_W-1:0]   period_last;
    logic [CNT_W-1:0]   per_cnt;

    assign key_raw = {KEY_DOWN_N, KEY_UP_N};

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source, independent of statement order.
    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            key_meta  <= '1;
            key_sync  <= '1;
            key_deb   <= '1;
            key_deb_q <= '1;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            key_meta  <= key_raw;
            key_sync  <= key_meta;
            key_deb_q <= key_deb;
            for (int i = 0; i < 2; i++) begin
                if (key_sync[i] == key_deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    key_deb[i] <= key_sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Only a debounced 1->0 transition is an event; releases are silent.
    assign press = key_deb_q & ~key_deb;

    // NOTE: every output of this block is given a default first, so no path
    // through the ifs can leave a value unassigned and infer a latch.
    always_comb begin
        nivel_next   = NIVEL;
        level_change = 1'b0;
        if (press[KEY_UP] && !press[KEY_DN] && NIVEL != LEVEL_MAX) begin
            nivel_next   = NIVEL + LEVEL_ONE;
            level_change = 1'b1;
        end else if (press[KEY_DN] && !press[KEY_UP] && NIVEL != '0) begin
            nivel_next   = NIVEL - LEVEL_ONE;
            level_change = 1'b1;
        end
    end

    assign period_last = BASE_CNT * (LEVELS_CNT - CNT_W'(NIVEL)) - CNT_ONE;

    // A real level change restarts the period, which also swallows a TICK due now.
    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            NIVEL   <= LEVEL_RESET;
            per_cnt <= '0;
            TICK    <= 1'b0;
        end else begin
            NIVEL <= nivel_next;
            if (level_change) begin
                per_cnt <= '0;
                TICK    <= 1'b0;
            end else if (ENABLE) begin
                if (per_cnt == period_last) begin
                    per_cnt <= '0;
                    TICK    <= 1'b1;
                end else begin
                    per_cnt <= per_cnt + CNT_ONE;
                    TICK    <= 1'b0;
                end
            end else begin
                TICK <= 1'b0;
            end
        end
    end

    assign LIMITE = (NIVEL == '0) || (NIVEL == LEVEL_MAX);

endmodule

// File: tb/tb_generador_velocidad.sv
// Scoreboard bench for generador_velocidad: stimulus queues expected TICK and
// level-change events by cycle, an independent monitor matches DUT activity.
module tb_generador_velocidad;

    logic       CLK_50     = 1'b0;
    logic       RST        = 1'b1;
    logic       ENABLE     = 1'b1;
    logic       KEY_UP_N   = 1'b1;
    logic       KEY_DOWN_N = 1'b1;
    logic       TICK;
    logic [1:0] NIVEL;
    logic       LIMITE;

    generador_velocidad #(
        .DEBOUNCE_CYCLES(4),
        .NUM_LEVELS     (4),
        .RESET_LEVEL    (1),
        .BASE_PERIOD    (5),
        .LEVEL_W        (2),
        .CNT_W          (8)
    ) dut (
        .CLK_50    (CLK_50),
        .RST       (RST),
        .ENABLE    (ENABLE),
        .KEY_UP_N  (KEY_UP_N),
        .KEY_DOWN_N(KEY_DOWN_N),
        .TICK      (TICK),
        .NIVEL     (NIVEL),
        .LIMITE    (LIMITE)
    );

    always #10 CLK_50 = ~CLK_50;

    typedef enum int {EV_TICK, EV_LEVEL} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       nivel;
        int       limite;
    } exp_t;

    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   last_nivel = 1;
    exp_t exp_q[$];

    // Clock edges since the most recent reset release.
    always @(posedge CLK_50 or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic push_exp(input ev_kind_t k, input int c, input int nv, input int lim);
        exp_t e;
        int   idx;
        e   = '{k, c, nv, lim};
        idx = exp_q.size();
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc > c) idx = i;
        end
        exp_q.insert(idx, e);
    endtask

    task automatic push_ticks(input int first, input int period, input int last);
        for (int c = first; c <= last; c += period) push_exp(EV_TICK, c, 0, 0);
    endtask

    task automatic observe(input ev_kind_t k);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected %s at cycle %0d: nivel %0d, no event expected",
                     k.name(), cyc, NIVEL);
        end else begin
            e = exp_q.pop_front();
            check("event kind", int'(k), int'(e.kind));
            check("event cycle", cyc, e.cyc);
            if (k == EV_LEVEL) begin
                check("nivel", int'(NIVEL), e.nivel);
                check("limite", int'(LIMITE), e.limite);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge CLK_50 or posedge RST) begin
        if (RST) begin
            last_nivel = 1;
        end else begin
            if (TICK) observe(EV_TICK);
            if (int'(NIVEL) != last_nivel) begin
                observe(EV_LEVEL);
                last_nivel = int'(NIVEL);
            end
        end
    end

    task automatic end_window();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing %s: expected at cycle %0d (nivel %0d), not seen by cycle %0d",
                     e.kind.name(), e.cyc, e.nivel, cyc);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge CLK_50);
    endtask

    // Called just after a falling edge; the short pulse ends before the next rising edge.
    task automatic do_reset();
        #1 end_window();
        #1 RST = 1'b1;
        #1;
        check("reset nivel", int'(NIVEL), 1);
        check("reset tick", int'(TICK), 0);
        check("reset limite", int'(LIMITE), 0);
        #2 RST = 1'b0;
    endtask

    // which: 0 = up, 1 = down, 2 = both on the same edge.
    task automatic press_key(input int which, input int at, input int len);
        wait_to(at);
        if (which != 1) KEY_UP_N = 1'b0;
        if (which != 0) KEY_DOWN_N = 1'b0;
        wait_to(at + len);
        KEY_UP_N   = 1'b1;
        KEY_DOWN_N = 1'b1;
    endtask

    initial begin
        @(negedge CLK_50);

        // Free-running at level 1: period 15, first TICK 15 edges after release.
        do_reset();
        push_ticks(15, 15, 45);
        wait_to(46);
        do_reset();

        // 3-cycle glitch filtered; 12-cycle press gives one increment 6 edges in.
        push_ticks(15, 15, 15);
        push_exp(EV_LEVEL, 17, 2, 0);
        push_ticks(27, 10, 47);
        press_key(0, 2, 3);
        press_key(0, 10, 12);
        wait_to(48);
        do_reset();

        // Saturation at both ends; ignored presses leave the period running.
        push_exp(EV_LEVEL, 12, 2, 0);
        push_ticks(22, 10, 22);
        push_exp(EV_LEVEL, 28, 3, 1);
        push_ticks(33, 5, 73);
        push_exp(EV_LEVEL, 76, 2, 0);
        push_ticks(86, 10, 86);
        push_exp(EV_LEVEL, 92, 1, 0);
        push_ticks(107, 15, 107);
        push_exp(EV_LEVEL, 108, 0, 1);
        push_ticks(128, 20, 148);
        for (int i = 0; i < 4; i++) press_key(0, 5 + 16 * i, 8);
        for (int i = 0; i < 4; i++) press_key(1, 69 + 16 * i, 8);
        wait_to(150);
        do_reset();

        // Simultaneous up and down: no level change, period undisturbed.
        push_ticks(15, 15, 45);
        press_key(2, 5, 25);
        wait_to(46);
        do_reset();

        // Disable 7 cycles into a period for 30 cycles; resume from held count.
        push_ticks(15, 15, 15);
        push_ticks(60, 15, 75);
        wait_to(22);
        ENABLE = 1'b0;
        wait_to(52);
        ENABLE = 1'b1;
        wait_to(76);
        do_reset();

        // Reach level 3, then reset while TICK is high; normal ticking follows.
        push_exp(EV_LEVEL, 12, 2, 0);
        push_ticks(22, 10, 22);
        push_exp(EV_LEVEL, 28, 3, 1);
        push_ticks(33, 5, 43);
        press_key(0, 5, 8);
        press_key(0, 21, 8);
        wait_to(43);
        do_reset();
        push_ticks(15, 15, 30);
        wait_to(31);
        #1 end_window();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
